load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access unit between the execute stage (ALU address, rs2 data, funct3) and a request/grant/response data bus.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-aligned bus transactions with byte enables.
- Formats load data with sign or zero extension for register-file writeback.
- Stalls the core while a transaction is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before abort with lsu_bus_error; 0 disables timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- lsu_valid  input  1  execute presents a memory op; held until lsu_done
- lsu_we  input  1  1=store, 0=load
- lsu_funct3  input  3  RV32I funct3 of the op
- lsu_addr  input  32  byte address (ALU result)
- lsu_wdata  input  32  store data (rs2)
- lsu_ready  output  1  unit idle, can accept a request
- lsu_stall  output  1  core must hold PC/instruction
- lsu_done  output  1  one-cycle completion pulse
- lsu_rdata  output  32  formatted load result, valid with lsu_done
- lsu_misaligned  output  1  pulses with lsu_done; no bus access made
- lsu_bus_error  output  1  pulses with lsu_done on timeout
- bus_req  output  1  bus request
- bus_we  output  1  bus write
- bus_addr  output  32  word address, bits[1:0]=0
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  response/write-ack
- bus_rdata  input  32  read word

Behaviour:
- Reset (async): state IDLE, counter 0. All outputs 0 except lsu_ready=1. bus_req drops immediately on reset, including mid-transaction. No response is awaited after reset.
- States:
  - IDLE: lsu_ready=1. On lsu_valid, capture we/funct3/addr/wdata.
    - If the op is misaligned → DONE with err_mis. Misaligned means: halfword with addr[0]=1; word with addr[1:0]≠0; or illegal funct3 (load 011/110/111, store >010).
    - Otherwise → REQ.
  - REQ: bus_req=1; bus_addr/we/be/wdata stable from registers. bus_gnt=1 → WAIT.
  - WAIT: bus_req=0. bus_rvalid=1 → capture formatted data → DONE. rvalid is never sampled in the grant cycle; earliest is grant+1.
  - DONE: lsu_done=1 for exactly one cycle, plus the appropriate error flag → IDLE. No request accepted in DONE. A still-high lsu_valid in the following IDLE is treated as a new op.
- Minimum latency for a legal access: accept cycle + REQ + WAIT + DONE. With gnt in the first REQ cycle and rvalid the next cycle, lsu_done fires 3 cycles after accept.
- lsu_stall = (IDLE & lsu_valid) | REQ | WAIT. It is 0 in DONE.
- Byte enables and write data:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << {addr[1],0}; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads: be is the same pattern as the corresponding store width; bus_we=0.
- Load format: select byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- lsu_rdata holds its value until the next load completes. Stores and error completions leave it unchanged; errors also leave rdata unchanged.
- Timeout: counter clears on accept and increments in REQ/WAIT. When count reaches TIMEOUT_CYCLES-1, go to DONE with lsu_bus_error, and bus_req deasserts. Any later rvalid is ignored.
- bus_rvalid outside WAIT is ignored.
- lsu_misaligned and lsu_bus_error are mutually exclusive.

Decomposition:
- Shared package:
  - funct3 constants F3_LB..F3_LHU, F3_SB..F3_SW.
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE}.
  - Function computing bus_be from funct3/addr.
- One combinational sub-module, lsu_load_formatter (funct3, addr[1:0], bus_rdata → lsu_rdata_next).

Test Plan:
- LW at addr 0x100, gnt in the first REQ cycle, rdata 0xDEADBEEF next cycle → bus_addr 0x100, be 1111, lsu_done 3 cycles after accept, lsu_rdata 0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF_0000 → be 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH at 0x102, wdata 0x1234ABCD, gnt delayed 4 cycles → bus_req held 5 cycles with addr 0x100, be 1100, wdata 0xABCDABCD; stall high throughout.
- LW at 0x101 → lsu_done + lsu_misaligned the cycle after accept; bus_req never asserts; lsu_rdata unchanged.
- TIMEOUT_CYCLES=8, gnt never asserted → lsu_done + lsu_bus_error 8 cycles after accept; bus_req low afterwards; late rvalid ignored.
- reset_n pulsed low during WAIT → bus_req/lsu_stall 0 immediately, lsu_ready 1; a following LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the byte-enable / store-lane / legality helpers used at request accept.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // funct3[1:0] encodes access width for both loads and stores.
    function automatic logic [3:0] lsu_byte_enable(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0]  funct3,
                                                   input logic [31:0] wdata);
        logic [31:0] data;
        case (funct3[1:0])
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    // Illegal funct3 encodings are reported the same way as misalignment.
    function automatic logic lsu_misaligned_op(input logic       we,
                                               input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic illegal;
        logic unaligned;
        if (we) begin
            illegal = (funct3 > F3_SW);
        end else begin
            illegal = (funct3 inside {3'b011, 3'b110, 3'b111});
        end
        case (funct3[1:0])
            2'b01:   unaligned = addr_lo[0];
            2'b10:   unaligned = (addr_lo != 2'b00);
            default: unaligned = 1'b0;
        endcase
        return illegal | unaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_formatter.sv
// Selects the addressed byte/halfword lane of a bus read word and applies
// sign or zero extension for register-file writeback.
module lsu_load_formatter
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] bus_rdata,
    output logic [31:0] lsu_rdata_next
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = bus_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = bus_rdata[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = byte_lane[addr_lo];
    assign sel_half = half_lane[addr_lo[1]];

    always_comb begin
        lsu_rdata_next = bus_rdata;
        case (funct3)
            F3_LB:   lsu_rdata_next = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   lsu_rdata_next = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  lsu_rdata_next = {24'h000000, sel_byte};
            F3_LHU:  lsu_rdata_next = {16'h0000, sel_half};
            default: lsu_rdata_next = bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: turns execute-stage memory ops into
// word-aligned req/gnt/rvalid bus transactions and formats load results.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misaligned,
    output logic        lsu_bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t  state_reg, state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        err_mis_reg;
    logic        err_to_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0] rdata_reg;
    logic [31:0] lsu_rdata_next;

    logic accept;
    logic mis_now;
    logic busy;
    logic timeout_hit;

    assign accept  = (state_reg == IDLE) && lsu_valid;
    assign mis_now = lsu_misaligned_op(lsu_we, lsu_funct3, lsu_addr[1:0]);
    assign busy    = (state_reg == REQ) || (state_reg == WAIT);

    // The comparison uses count+1 so the abort lands TIMEOUT_CYCLES after accept.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (32'(count_reg) + 32'd1) >= (32'(TIMEOUT_CYCLES) - 32'd1);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (lsu_valid) state_next = mis_now ? DONE : REQ;
            REQ: begin
                if (timeout_hit)  state_next = DONE;
                else if (bus_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (timeout_hit || bus_rvalid) state_next = DONE;
            end
            DONE: state_next = IDLE;
        endcase
    end

    always_comb begin
        lsu_ready = 1'b0;
        lsu_stall = 1'b0;
        lsu_done  = 1'b0;
        bus_req   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                lsu_ready = 1'b1;
                lsu_stall = lsu_valid;
            end
            REQ: begin
                lsu_stall = 1'b1;
                bus_req   = 1'b1;
            end
            WAIT: lsu_stall = 1'b1;
            DONE: lsu_done  = 1'b1;
        endcase
    end

    assign lsu_misaligned = lsu_done & err_mis_reg;
    assign lsu_bus_error  = lsu_done & err_to_reg;
    assign lsu_rdata      = rdata_reg;
    assign bus_we         = we_reg;
    assign bus_addr       = {addr_reg[31:2], 2'b00};
    assign bus_be         = be_reg;
    assign bus_wdata      = wdata_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_reg      <= 1'b0;
            funct3_reg  <= 3'b000;
            addr_reg    <= 32'h0;
            be_reg      <= 4'h0;
            wdata_reg   <= 32'h0;
            err_mis_reg <= 1'b0;
            err_to_reg  <= 1'b0;
            count_reg   <= '0;
            rdata_reg   <= 32'h0;
        end else begin
            if (accept) begin
                we_reg      <= lsu_we;
                funct3_reg  <= lsu_funct3;
                addr_reg    <= lsu_addr;
                be_reg      <= lsu_byte_enable(lsu_funct3, lsu_addr[1:0]);
                wdata_reg   <= lsu_store_data(lsu_funct3, lsu_wdata);
                err_mis_reg <= mis_now;
                err_to_reg  <= 1'b0;
                count_reg   <= '0;
            end
            if (busy) begin
                count_reg <= count_reg + 1'b1;
                if (timeout_hit) err_to_reg <= 1'b1;
            end
            // Stores complete on the write-ack without touching the load result.
            if ((state_reg == WAIT) && !timeout_hit && bus_rvalid && !we_reg) begin
                rdata_reg <= lsu_rdata_next;
            end
        end
    end

    lsu_load_formatter u_load_formatter (
        .funct3         (funct3_reg),
        .addr_lo        (addr_reg[1:0]),
        .bus_rdata      (bus_rdata),
        .lsu_rdata_next (lsu_rdata_next)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-op timing/format model drives a
// per-cycle compare process, plus literal checks pinning the model.
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b000;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_ready, lsu_stall, lsu_done, lsu_misaligned, lsu_bus_error;
    logic [31:0] lsu_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lsu_valid      (lsu_valid),
        .lsu_we         (lsu_we),
        .lsu_funct3     (lsu_funct3),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_ready      (lsu_ready),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .lsu_rdata      (lsu_rdata),
        .lsu_misaligned (lsu_misaligned),
        .lsu_bus_error  (lsu_bus_error),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Current op as seen by the model; op_k counts cycles since accept (-1 = idle).
    int          op_k = -1;
    logic        op_we = 1'b0;
    logic [2:0]  op_f3 = 3'b000;
    logic [31:0] op_addr = 32'h0, op_wdata = 32'h0, op_word = 32'h0;
    int          op_gd = 0, op_rd = 0, op_kind = 0, op_done_k = 0;
    logic [31:0] exp_rdata = 32'h0;
    bit          chk_on = 1'b0;

    int          req_cycles = 0;
    int          seen_done_k = -1;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    logic [3:0]  last_be = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_misaligned(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((int'(a[1:0]) % model_size(f3)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = model_size(f3);
        return 4'(((1 << n) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = model_size(f3);
        if (n == 1) return {24'h0, wd[7:0]} * 32'h01010101;
        if (n == 2) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] x;
        int n;
        n = model_size(f3);
        x = w >> (8 * int'(a[1:0]));
        if (n == 1) return f3[2] ? {24'h0, x[7:0]} : 32'($signed(x[7:0]));
        if (n == 2) return f3[2] ? {16'h0, x[15:0]} : 32'($signed(x[15:0]));
        return w;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            logic e_ready, e_stall, e_req, e_done;
            e_ready = (op_k <= 0);
            e_stall = (op_k >= 0) && (op_k < op_done_k);
            e_req   = (op_k >= 1) && (((op_kind == 0) && (op_k <= op_gd + 1)) ||
                                      ((op_kind == 2) && (op_k < op_done_k)));
            e_done  = (op_k >= 0) && (op_k == op_done_k);
            if (e_done && (op_kind == 0) && !op_we) exp_rdata = model_load(op_f3, op_addr, op_word);
            if (bus_req) begin
                req_cycles++;
                last_addr  = bus_addr;
                last_be    = bus_be;
                last_wdata = bus_wdata;
            end
            if (lsu_done) seen_done_k = op_k;
            chk("lsu_ready", {31'h0, lsu_ready}, {31'h0, e_ready});
            chk("lsu_stall", {31'h0, lsu_stall}, {31'h0, e_stall});
            chk("bus_req", {31'h0, bus_req}, {31'h0, e_req});
            chk("lsu_done", {31'h0, lsu_done}, {31'h0, e_done});
            chk("lsu_misaligned", {31'h0, lsu_misaligned}, {31'h0, e_done && (op_kind == 1)});
            chk("lsu_bus_error", {31'h0, lsu_bus_error}, {31'h0, e_done && (op_kind == 2)});
            chk("lsu_rdata", lsu_rdata, exp_rdata);
            if (e_req) begin
                chk("bus_addr", bus_addr, {op_addr[31:2], 2'b00});
                chk("bus_be", {28'h0, bus_be}, {28'h0, model_be(op_f3, op_addr)});
                chk("bus_we", {31'h0, bus_we}, {31'h0, op_we});
                if (op_we) chk("bus_wdata", bus_wdata, model_wdata(op_f3, op_wdata));
            end
        end
    end

    // gd < 0 means the bus never grants; abort_k >= 0 pulses reset at that cycle.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rd,
                          input logic [31:0] word, input int abort_k);
        @(posedge clk); #1;
        op_we = we; op_f3 = f3; op_addr = a; op_wdata = wd; op_word = word;
        op_gd = gd; op_rd = rd;
        if (model_misaligned(we, f3, a)) begin
            op_kind = 1; op_done_k = 1;
        end else if (gd < 0) begin
            op_kind = 2; op_done_k = T;
        end else begin
            op_kind = 0; op_done_k = gd + rd + 3;
        end
        req_cycles = 0;
        seen_done_k = -1;
        lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        bus_rdata = word;
        op_k = 0;
        $display("txn we=%0d f3=%0d addr=%h wdata=%h gnt_delay=%0d rv_delay=%0d kind=%0d",
                 we, f3, a, wd, gd, rd, op_kind);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            op_k++;
            if (op_k > op_done_k) break;
            if (op_k == abort_k) begin
                chk_on = 1'b0;
                lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; op_k = -1;
                reset_n = 1'b0;
                #1;
                chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
                chk("rst_lsu_stall", {31'h0, lsu_stall}, 32'h0);
                chk("rst_lsu_ready", {31'h0, lsu_ready}, 32'h1);
                chk("rst_lsu_done", {31'h0, lsu_done}, 32'h0);
                exp_rdata = 32'h0;
                @(posedge clk); #3;
                reset_n = 1'b1;
                chk_on = 1'b1;
                return;
            end
            bus_gnt    = (op_kind == 0) && (op_k == gd + 1);
            bus_rvalid = (op_kind == 0) && (op_k == gd + rd + 2);
        end
        lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; op_k = -1;
        chk("done_cycle", seen_done_k, op_done_k);
    endtask

    initial begin
        #2;
        chk("reset_ready", {31'h0, lsu_ready}, 32'h1);
        chk("reset_stall", {31'h0, lsu_stall}, 32'h0);
        chk("reset_done", {31'h0, lsu_done}, 32'h0);
        chk("reset_bus_req", {31'h0, bus_req}, 32'h0);
        chk("reset_rdata", lsu_rdata, 32'h0);
        chk("reset_be", {28'h0, bus_be}, 32'h0);
        @(posedge clk); @(posedge clk); #3;
        reset_n = 1'b1;
        chk_on = 1'b1;

        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, -1);
        chk("lw_latency", seen_done_k, 32'd3);
        chk("lw_rdata", lsu_rdata, 32'hDEADBEEF);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", {28'h0, last_be}, 32'hF);

        run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000, -1);
        chk("lb_rdata", lsu_rdata, 32'hFFFFFF80);
        chk("lb_be", {28'h0, last_be}, 32'h8);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000, -1);
        chk("lbu_rdata", lsu_rdata, 32'h00000080);

        run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 4, 0, 32'h0, -1);
        chk("sh_req_cycles", req_cycles, 32'd5);
        chk("sh_addr", last_addr, 32'h100);
        chk("sh_be", {28'h0, last_be}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_rdata_kept", lsu_rdata, 32'h00000080);

        run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11111111, -1);
        chk("mis_latency", seen_done_k, 32'd1);
        chk("mis_no_req", req_cycles, 32'd0);
        chk("mis_rdata_kept", lsu_rdata, 32'h00000080);

        run_op(1'b0, 3'b010, 32'h200, 32'h0, -1, 0, 32'h22222222, -1);
        chk("to_latency", seen_done_k, 32'd8);
        chk("to_req_cycles", req_cycles, 32'd7);
        @(posedge clk); #1; bus_rvalid = 1'b1;
        @(posedge clk); #1; bus_rvalid = 1'b0;
        chk("late_rvalid_rdata", lsu_rdata, 32'h00000080);

        run_op(1'b0, 3'b001, 32'h102, 32'h0, 1, 2, 32'h80011234, -1);
        chk("lh_rdata", lsu_rdata, 32'hFFFF8001);
        run_op(1'b0, 3'b101, 32'h100, 32'h0, 0, 1, 32'h80011234, -1);
        chk("lhu_rdata", lsu_rdata, 32'h00001234);
        run_op(1'b1, 3'b000, 32'h101, 32'h00000055, 2, 1, 32'h0, -1);
        chk("sb_be", {28'h0, last_be}, 32'h2);
        chk("sb_wdata", last_wdata, 32'h55555555);
        run_op(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 0, 32'h0, -1);
        run_op(1'b0, 3'b011, 32'h108, 32'h0, 0, 0, 32'h0, -1);
        run_op(1'b1, 3'b011, 32'h108, 32'h0, 0, 0, 32'h0, -1);
        run_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, -1);

        run_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 3, 32'h33333333, 3);
        chk("post_reset_rdata", lsu_rdata, 32'h0);
        run_op(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 32'h0BADF00D, -1);
        chk("post_reset_lw", lsu_rdata, 32'h0BADF00D);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
